// File: rtl/axi4_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : axi4_mem_pkg                                               |
// | Description : Shared response/burst encodings, FSM state types and a     |
// |               small helper for the axi4_burst_mem slave memory.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package axi4_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // True only for the FIXED and INCR burst types.
  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_mem_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : axi4_mem_addr_gen                                          |
// | Description : Word-index step for one burst channel. Produces the index  |
// |               of the following beat and whether the given index lies     |
// |               inside the memory.                                         |
// | Revision    : 1.0 - initial release                                      |
// |                                                                          |
// | Ports       : idx_i       current word index                             |
// |               burst_i     AXI burst type of the transaction              |
// |               next_idx_o  index of the next beat                         |
// |               in_range_o  idx_i < MEM_SIZE                               |
// +--------------------------------------------------------------------------+
module axi4_mem_addr_gen
  import axi4_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 1024
) (
  input  logic [ADDR_WIDTH-1:0] idx_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_idx_o,
  output logic                  in_range_o
);

  // Saturate at all-ones so an INCR burst can never wrap back into the
  // valid range and alias low memory; all-ones is always out of range.
  always_comb begin
    next_idx_o = idx_i;
    if ((burst_i == BURST_INCR) && (idx_i != '1)) begin
      next_idx_o = idx_i + ADDR_WIDTH'(1);
    end
  end

  assign in_range_o = (idx_i < ADDR_WIDTH'(MEM_SIZE));

endmodule
`default_nettype wire

// File: rtl/axi4_burst_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : axi4_burst_mem                                             |
// | Description : AXI4 slave memory with independent FIXED/INCR write and    |
// |               read burst engines, ID echo, byte strobes and SLVERR       |
// |               reporting. DATA_WIDTH must be 32, 64 or 128.               |
// | Revision    : 1.0 - initial release                                      |
// |                                                                          |
// | Ports       : clk, reset (sync, active low)                              |
// |               AW : awid awaddr awlen awburst awvalid awready             |
// |               W  : wdata wstrb wlast wvalid wready                       |
// |               B  : bid bresp bvalid bready                               |
// |               AR : arid araddr arlen arburst arvalid arready             |
// |               R  : rid rdata rresp rlast rvalid rready                   |
// +--------------------------------------------------------------------------+
module axi4_burst_mem
  import axi4_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_SIZE   = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int OFF_BITS  = $clog2(NUM_BYTES);
  localparam int MEM_AW    = $clog2(MEM_SIZE);

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  // ---------------------------------------------------------------- write
  wr_state_t             wr_state_q, wr_state_d;
  logic [ID_WIDTH-1:0]   wr_id_q, wr_id_d;
  logic [ADDR_WIDTH-1:0] wr_idx_q, wr_idx_d;
  logic [7:0]            wr_len_q, wr_len_d;
  logic [7:0]            wr_cnt_q, wr_cnt_d;
  logic [1:0]            wr_burst_q, wr_burst_d;
  logic                  wr_err_q, wr_err_d;

  logic [ADDR_WIDTH-1:0] w_wr_next_idx;
  logic                  w_wr_in_range;
  logic                  w_aw_hs, w_w_hs, w_b_hs, w_wr_last_beat, w_wr_we;

  axi4_mem_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_SIZE(MEM_SIZE)) u_wr_gen (
    .idx_i      (wr_idx_q),
    .burst_i    (wr_burst_q),
    .next_idx_o (w_wr_next_idx),
    .in_range_o (w_wr_in_range)
  );

  // Every output is forced low while reset is held, not only after the edge.
  assign awready = reset & (wr_state_q == W_IDLE);
  assign wready  = reset & (wr_state_q == W_DATA);
  assign bvalid  = reset & (wr_state_q == W_RESP);
  assign bid     = reset ? wr_id_q : '0;
  assign bresp   = (reset && wr_err_q) ? RESP_SLVERR : RESP_OKAY;

  assign w_aw_hs        = awvalid & awready;
  assign w_w_hs         = wvalid & wready;
  assign w_b_hs         = bvalid & bready;
  assign w_wr_last_beat = (wr_cnt_q == wr_len_q);
  assign w_wr_we        = w_w_hs & w_wr_in_range & burst_supported(wr_burst_q);

  always_comb begin
    wr_state_d = wr_state_q;
    wr_id_d    = wr_id_q;
    wr_idx_d   = wr_idx_q;
    wr_len_d   = wr_len_q;
    wr_cnt_d   = wr_cnt_q;
    wr_burst_d = wr_burst_q;
    wr_err_d   = wr_err_q;
    case (wr_state_q)
      W_IDLE: begin
        if (w_aw_hs) begin
          wr_state_d = W_DATA;
          wr_id_d    = awid;
          wr_idx_d   = awaddr >> OFF_BITS;
          wr_len_d   = awlen;
          wr_cnt_d   = 8'd0;
          wr_burst_d = awburst;
          wr_err_d   = 1'b0;
        end
      end
      W_DATA: begin
        if (w_w_hs) begin
          // Burst length is defined by awlen; wlast only feeds the error flag.
          if (!burst_supported(wr_burst_q) || !w_wr_in_range ||
              (wlast != w_wr_last_beat)) begin
            wr_err_d = 1'b1;
          end
          if (w_wr_last_beat) begin
            wr_state_d = W_RESP;
          end else begin
            wr_cnt_d = wr_cnt_q + 8'd1;
            wr_idx_d = w_wr_next_idx;
          end
        end
      end
      W_RESP: begin
        if (w_b_hs) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_state_q <= W_IDLE;
      wr_id_q    <= '0;
      wr_idx_q   <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
      wr_burst_q <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_id_q    <= wr_id_d;
      wr_idx_q   <= wr_idx_d;
      wr_len_q   <= wr_len_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_burst_q <= wr_burst_d;
      wr_err_q   <= wr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_we) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wstrb[b]) begin
          mem[wr_idx_q[MEM_AW-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // ----------------------------------------------------------------- read
  rd_state_t             rd_state_q, rd_state_d;
  logic [ID_WIDTH-1:0]   rd_id_q, rd_id_d;
  logic [ADDR_WIDTH-1:0] rd_nidx_q, rd_nidx_d;
  logic [7:0]            rd_len_q, rd_len_d;
  logic [7:0]            rd_cnt_q, rd_cnt_d;
  logic [1:0]            rd_burst_q, rd_burst_d;
  logic [1:0]            rd_resp_q, rd_resp_d;
  logic                  rd_last_q, rd_last_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic [ADDR_WIDTH-1:0] w_rd_load_idx, w_rd_next_idx;
  logic [1:0]            w_rd_load_burst;
  logic                  w_rd_in_range, w_rd_load_ok, w_rd_load;
  logic                  w_ar_hs, w_r_hs;

  // The generator looks at the beat about to be loaded into the output
  // registers: the AR address when idle, else the pre-computed next index.
  // rd_nidx_q therefore always runs one beat ahead of the presented data.
  assign w_rd_load_idx   = (rd_state_q == R_IDLE) ? (araddr >> OFF_BITS) : rd_nidx_q;
  assign w_rd_load_burst = (rd_state_q == R_IDLE) ? arburst : rd_burst_q;

  axi4_mem_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_SIZE(MEM_SIZE)) u_rd_gen (
    .idx_i      (w_rd_load_idx),
    .burst_i    (w_rd_load_burst),
    .next_idx_o (w_rd_next_idx),
    .in_range_o (w_rd_in_range)
  );

  assign arready = reset & (rd_state_q == R_IDLE);
  assign rvalid  = reset & (rd_state_q == R_DATA);
  assign rid     = reset ? rd_id_q : '0;
  assign rdata   = reset ? rd_data_q : '0;
  assign rresp   = reset ? rd_resp_q : RESP_OKAY;
  assign rlast   = reset & rd_last_q;

  assign w_ar_hs      = arvalid & arready;
  assign w_r_hs       = rvalid & rready;
  assign w_rd_load    = w_ar_hs | (w_r_hs & ~rd_last_q);
  assign w_rd_load_ok = w_rd_in_range & burst_supported(w_rd_load_burst);

  always_comb begin
    rd_state_d = rd_state_q;
    rd_id_d    = rd_id_q;
    rd_nidx_d  = rd_nidx_q;
    rd_len_d   = rd_len_q;
    rd_cnt_d   = rd_cnt_q;
    rd_burst_d = rd_burst_q;
    rd_resp_d  = rd_resp_q;
    rd_last_d  = rd_last_q;
    case (rd_state_q)
      R_IDLE: begin
        if (w_ar_hs) begin
          rd_state_d = R_DATA;
          rd_id_d    = arid;
          rd_len_d   = arlen;
          rd_cnt_d   = 8'd0;
          rd_burst_d = arburst;
          rd_last_d  = (arlen == 8'd0);
          rd_nidx_d  = w_rd_next_idx;
          rd_resp_d  = w_rd_load_ok ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_DATA: begin
        if (w_r_hs) begin
          if (rd_last_q) begin
            rd_state_d = R_IDLE;
          end else begin
            rd_cnt_d  = rd_cnt_q + 8'd1;
            rd_last_d = ((rd_cnt_q + 8'd1) == rd_len_q);
            rd_nidx_d = w_rd_next_idx;
            rd_resp_d = w_rd_load_ok ? RESP_OKAY : RESP_SLVERR;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_state_q <= R_IDLE;
      rd_id_q    <= '0;
      rd_nidx_q  <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
      rd_burst_q <= '0;
      rd_resp_q  <= RESP_OKAY;
      rd_last_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_id_q    <= rd_id_d;
      rd_nidx_q  <= rd_nidx_d;
      rd_len_q   <= rd_len_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_burst_q <= rd_burst_d;
      rd_resp_q  <= rd_resp_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // Separate process so the memory read stays a registered RAM port; a write
  // to the same word on the same edge is not visible here (old data returned).
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else if (w_rd_load) begin
      rd_data_q <= w_rd_load_ok ? mem[w_rd_load_idx[MEM_AW-1:0]] : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_burst_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_axi4_burst_mem                                          |
// | Description : Self-checking bench for axi4_burst_mem: table of single    |
// |               write/read pairs plus hand-written burst, error, reset and |
// |               read/write collision sequences, with B/R scoreboards.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_axi4_burst_mem;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int MS = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [IW-1:0] awid = '0;
  logic [AW-1:0] awaddr = '0;
  logic [7:0]    awlen = '0;
  logic [1:0]    awburst = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wlast = 1'b0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [IW-1:0] bid;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [IW-1:0] arid = '0;
  logic [AW-1:0] araddr = '0;
  logic [7:0]    arlen = '0;
  logic [1:0]    arburst = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready = 1'b0;

  always #5 clk = ~clk;

  axi4_burst_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_SIZE(MS)) dut (
    .clk(clk), .reset(reset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_exp_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [31:0]   data;
    logic [1:0]    resp;
    logic          last;
  } r_exp_t;

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  b_exp_t      b_exp[$];
  r_exp_t      r_exp[$];
  logic [31:0] wbuf[$];
  logic [3:0]  sbuf[$];
  logic [31:0] model [MS];
  vec_t        vecs [6];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives AW, all W beats (wlast on beat wlast_at) and collects B.
  // Expected response comes from a behavioural model of the memory.
  task automatic do_write(input logic [IW-1:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst,
                          input int wlast_at);
    bit     err = 1'b0;
    bit     hs;
    int     idx;
    b_exp_t e;
    for (int i = 0; i <= int'(len); i++) begin
      idx = int'(addr >> 2) + ((burst == 2'b01) ? i : 0);
      if (burst > 2'b01) err = 1'b1;
      else if (idx >= MS) err = 1'b1;
      else begin
        for (int b = 0; b < 4; b++)
          if (sbuf[i][b]) model[idx][b*8 +: 8] = wbuf[i][b*8 +: 8];
      end
      if ((i == wlast_at) != (i == int'(len))) err = 1'b1;
    end
    b_exp.push_back('{id, err ? 2'b10 : 2'b00});

    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk); hs = awready; tick();
    end
    awvalid = 1'b0;
    if (!hs) timeout("aw_handshake");

    for (int i = 0; i <= int'(len); i++) begin
      wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == wlast_at); wvalid = 1'b1;
      hs = 1'b0;
      for (int c = 0; c < 20 && !hs; c++) begin
        @(negedge clk); hs = wready; tick();
      end
      if (!hs) timeout("w_handshake");
    end
    wvalid = 1'b0; wlast = 1'b0;

    bready = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk);
      if (bvalid) begin
        hs = 1'b1;
        e = b_exp.pop_front();
        chk("bid", bid, e.id);
        chk("bresp", bresp, e.resp);
      end
      tick();
    end
    bready = 1'b0;
    if (!hs) timeout("b_handshake");
  endtask

  // Issues AR and drains R. With use_model the expected beats are pushed
  // from the model here; otherwise the caller has already pushed them.
  // toggle drives rready 1,0,1,0... and checks output stability on stalls.
  task automatic do_read(input logic [IW-1:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst,
                         input bit toggle, input bit use_model);
    bit          hs, have_snap;
    int          idx, got, cyc;
    bit          ok;
    r_exp_t      e;
    logic [31:0] snap_data;
    logic        snap_last;
    if (use_model) begin
      for (int i = 0; i <= int'(len); i++) begin
        idx = int'(addr >> 2) + ((burst == 2'b01) ? i : 0);
        ok  = (burst <= 2'b01) && (idx < MS);
        r_exp.push_back('{id, ok ? model[idx] : 32'h0, ok ? 2'b00 : 2'b10, i == int'(len)});
      end
    end

    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk); hs = arready; tick();
    end
    arvalid = 1'b0;
    if (!hs) timeout("ar_handshake");

    got = 0; cyc = 0; have_snap = 1'b0;
    snap_data = '0; snap_last = 1'b0;
    while (got <= int'(len) && cyc < 100) begin
      rready = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (rvalid) begin
        if (have_snap) begin
          chk("rdata_stable", rdata, snap_data);
          chk("rlast_stable", rlast, snap_last);
          have_snap = 1'b0;
        end
        if (rready) begin
          if (r_exp.size() == 0) begin
            timeout("r_unexpected_beat");
          end else begin
            e = r_exp.pop_front();
            chk("rid", rid, e.id);
            chk("rdata", rdata, e.data);
            chk("rresp", rresp, e.resp);
            chk("rlast", rlast, e.last);
          end
          got++;
        end else begin
          snap_data = rdata; snap_last = rlast; have_snap = 1'b1;
        end
      end
      tick();
      cyc++;
    end
    rready = 1'b0;
    if (got <= int'(len)) timeout("r_beats");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h10,   32'hDEADBEEF, 4'hF, 32'h10,   32'hDEADBEEF, 2'b00};
    vecs[1] = '{32'h100,  32'hFFFFFFFF, 4'hF, 32'h100,  32'hFFFFFFFF, 2'b00};
    vecs[2] = '{32'h100,  32'h11223344, 4'h5, 32'h100,  32'hFF22FF44, 2'b00};
    vecs[3] = '{32'h100,  32'hAABBCCDD, 4'hA, 32'h100,  32'hAA22CC44, 2'b00};
    vecs[4] = '{32'h13,   32'h0BADF00D, 4'hF, 32'h10,   32'h0BADF00D, 2'b00};
    vecs[5] = '{32'h1000, 32'h12345678, 4'hF, 32'h1000, 32'h00000000, 2'b10};
    for (int i = 0; i < MS; i++) model[i] = '0;

    // Reset values, both while held and just after release.
    repeat (3) tick();
    @(negedge clk);
    chk("rst_awready", awready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_awready", awready, 1'b1);
    chk("post_rst_arready", arready, 1'b1);
    chk("post_rst_wready", wready, 1'b0);
    tick();

    // Table: single-beat write then read-back.
    for (int i = 0; i < 6; i++) begin
      wbuf.delete(); sbuf.delete();
      wbuf.push_back(vecs[i].wdata); sbuf.push_back(vecs[i].wstrb);
      do_write(IW'(i), vecs[i].waddr, 8'd0, 2'b01, 0);
      r_exp.push_back('{IW'(i + 8), vecs[i].rdata, vecs[i].rresp, 1'b1});
      do_read(IW'(i + 8), vecs[i].raddr, 8'd0, 2'b01, 1'b0, 1'b0);
    end

    // INCR burst of four, read back with rready toggling.
    wbuf = '{32'd1, 32'd2, 32'd3, 32'd4};
    sbuf = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_write(4'd2, 32'h40, 8'd3, 2'b01, 3);
    r_exp.push_back('{4'd5, 32'd1, 2'b00, 1'b0});
    r_exp.push_back('{4'd5, 32'd2, 2'b00, 1'b0});
    r_exp.push_back('{4'd5, 32'd3, 2'b00, 1'b0});
    r_exp.push_back('{4'd5, 32'd4, 2'b00, 1'b1});
    do_read(4'd5, 32'h40, 8'd3, 2'b01, 1'b1, 1'b0);

    // FIXED burst: the last beat wins.
    wbuf = '{32'hA, 32'hB, 32'hC};
    sbuf = '{4'hF, 4'hF, 4'hF};
    do_write(4'd3, 32'h20, 8'd2, 2'b00, 2);
    r_exp.push_back('{4'd1, 32'hC, 2'b00, 1'b1});
    do_read(4'd1, 32'h20, 8'd0, 2'b01, 1'b0, 1'b0);

    // INCR burst running off the top of memory.
    wbuf = '{32'h111, 32'h222, 32'h333, 32'h444};
    sbuf = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_write(4'd4, 32'((MS - 2) * 4), 8'd3, 2'b01, 3);
    do_read(4'd6, 32'((MS - 2) * 4), 8'd3, 2'b01, 1'b0, 1'b1);

    // Unsupported burst type: beats consumed, memory untouched.
    wbuf = '{32'h99999999, 32'h88888888};
    sbuf = '{4'hF, 4'hF};
    do_write(4'd7, 32'h10, 8'd1, 2'b10, 1);
    do_read(4'd7, 32'h10, 8'd0, 2'b01, 1'b0, 1'b1);
    do_read(4'd7, 32'h10, 8'd0, 2'b11, 1'b0, 1'b1);

    // Early wlast on a two-beat burst.
    wbuf = '{32'h5, 32'h6};
    sbuf = '{4'hF, 4'hF};
    do_write(4'd9, 32'h80, 8'd1, 2'b01, 0);

    // Reset in the middle of a read burst.
    r_exp.delete();
    arid = 4'd3; araddr = 32'h40; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1;
    @(negedge clk);
    chk("mid_rst_arready_before", arready, 1'b1);
    tick();
    arvalid = 1'b0; rready = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_rst_rvalid", rvalid, 1'b0);
    chk("mid_rst_arready", arready, 1'b0);
    chk("mid_rst_rdata", rdata, 32'h0);
    tick();
    reset = 1'b1; rready = 1'b0;
    @(negedge clk);
    chk("after_rst_arready", arready, 1'b1);
    chk("after_rst_rvalid", rvalid, 1'b0);
    tick();
    do_read(4'd2, 32'h40, 8'd1, 2'b01, 1'b0, 1'b1);

    // Write beat and AR load hit the same word on the same edge.
    awid = 4'd6; awaddr = 32'h10; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    @(negedge clk);
    chk("coll_awready", awready, 1'b1);
    tick();
    awvalid = 1'b0;
    wdata = 32'h5555AAAA; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    arid = 4'd7; araddr = 32'h10; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
    @(negedge clk);
    chk("coll_wready", wready, 1'b1);
    chk("coll_arready", arready, 1'b1);
    tick();
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    chk("coll_rvalid", rvalid, 1'b1);
    chk("coll_rdata_old", rdata, 32'h0BADF00D);
    chk("coll_rlast", rlast, 1'b1);
    chk("coll_rid", rid, 4'd7);
    chk("coll_bvalid", bvalid, 1'b1);
    chk("coll_bresp", bresp, 2'b00);
    chk("coll_bid", bid, 4'd6);
    tick();
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    model[4] = 32'h5555AAAA;
    do_read(4'd8, 32'h10, 8'd0, 2'b01, 1'b0, 1'b1);

    chk("b_scoreboard_empty", 32'(b_exp.size()), 32'd0);
    chk("r_scoreboard_empty", 32'(r_exp.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
